conv_3x3_array: RTL and testbench
=================================

Name: conv_3x3_array

Overview:
- Parametrised 3x3 convolution engine: N_OUT output-channel PEs share one 3x3 window of IN_LANES packed signed int8 input channels per beat.
- Each PE accumulates across a group of input-channel beats, adds its bias and applies a per-group post-processing mode: raw, ReLU, leaky or int8 requantise.
- Adds a valid/ready handshake with full-pipeline stall.
- Sits between the line-buffer/window generator and the output writer in the conv datapath.

Parameters:
- N_OUT, 8, number of output-channel PEs.
- IN_LANES, 8, input channels packed per pixel word.
- DATA_W, 8, signed pixel/weight width.
- ACC_W, 32, accumulator, bias and output width.
- RQ_SHIFT, 16, right shift applied in requantise mode.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- last_channel  in  1  beat is the final input-channel group of the window.
- mode  in  2  00 raw, 01 ReLU, 10 leaky, 11 requantise.
- rq_scale  in  16  unsigned requantise multiplier.
- pixels[0:2][0:2]  in  IN_LANES*DATA_W  3x3 window; lane l at bits [l*DATA_W +: DATA_W].
- weights[0:N_OUT-1]  in  9*IN_LANES*DATA_W  tap (r*3+c), lane l at bits [((r*3+c)*IN_LANES+l)*DATA_W +: DATA_W].
- biases[0:N_OUT-1]  in  ACC_W  signed bias.
- outs[0:N_OUT-1]  out  ACC_W  signed results.
- out_valid  out  1  outs valid.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (async, any time): out_valid=0, outs=0, all pipeline valids=0, accumulators=0, group state=FIRST, latched mode=00. Any partially accumulated group is discarded.
- Stall enable: en = !(out_valid && !out_ready). in_ready = en, combinational.
- All stages advance only when en=1. Inputs are sampled only on an accepting edge.
- Pipeline, 4 register stages:
  - S1: products, signed DATA_W x DATA_W.
  - S2: per-PE reduction of 9*IN_LANES products, sign-extended to ACC_W.
  - S3: accumulate.
  - S4: post-process into the output register.
- Latency: if the last_channel beat is accepted on edge k and out_ready stays 1, out_valid=1 after edge k+3. Throughput is 1 beat/cycle.
- Group FSM, two states:
  - FIRST: an accepted beat loads acc = bias + sum and latches mode. If last_channel=1 the group completes at once (single-beat group) and the state stays FIRST. Otherwise go to ACCUM.
  - ACCUM: acc += sum. A beat with last_channel=1 completes the group and returns to FIRST.
  - mode changes mid-group are ignored.
  - biases and rq_scale are sampled on the FIRST beat and with the group-completing beat respectively; both travel down the pipe.
- Arithmetic: two's-complement wrap at ACC_W, no saturation in accumulation.
- Post-process on a completed group's acc a:
  - raw: out = a.
  - ReLU: out = (a<0) ? 0 : a.
  - leaky: out = (a<0) ? a>>>3 (arithmetic) : a.
  - requantise: p = a * zero-extended rq_scale (ACC_W+17 bits, signed); q = (p + 2^(RQ_SHIFT-1)) >>> RQ_SHIFT; saturate q to [-128,127]; sign-extend to ACC_W.
- Output register:
  - Loads only on a group completion with en=1. Non-final beats never touch outs.
  - While out_valid && !out_ready, outs and out_valid are held stable.
  - Consume and new completion on the same edge: outs take the new value and out_valid stays 1.
  - Consume with no completion: out_valid falls to 0 and outs hold their last value.
- All N_OUT PEs share one group FSM and one control pipeline; out_valid is therefore common to all PEs.

Decomposition:
- Shared package conv_pkg: mode encoding enum (MODE_RAW, MODE_RELU, MODE_LEAKY, MODE_RQ), LEAKY_SHIFT=3, int8 saturation limits, helper function for the lane/tap slice index.
- Sub-module conv_pe_mac: one PE datapath covering S1–S4 arithmetic for one output channel, with en, first/last strobes and mode inputs.
- conv_3x3_array owns the handshake, group FSM and control valid pipeline, and instantiates N_OUT copies of conv_pe_mac.

Test Plan:
- Raw multi-beat: all pixel/weight bytes = +1 (sum 72/beat), bias 10, mode 00, beats with last_channel 0,0,1, out_ready=1 -> outs all 226, out_valid one cycle, 3 edges after the 3rd accept.
- ReLU/leaky: pixels +1, weights -1, single-beat group, bias 0 -> mode 01 gives 0; mode 10 gives -9.
- Requantise: pixels/weights +1, bias 11, 3 beats (acc 227), rq_scale 0x8000 -> 114. Same with rq_scale 0xFFFF -> 127 (saturate).
- Backpressure: complete group A (226), hold out_ready=0, then offer group B (bias 0, 1 beat) -> in_ready=0, outs stay 226. Release out_ready -> A consumed, B=72 appears 3 cycles later.
- Reset mid-group: accept 2 non-final beats, pulse rst, then a 1-beat group with bias 5 -> out 77, no residue from the aborted group.
- Mode mid-group: first beat mode 10, later beats mode 00, final acc -72 -> out -9 (latched mode honoured).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution array.
// Mode encoding, group FSM states, control-pipe record and window slice indexing.
package conv_pkg;

    localparam int RQ_SCALE_W  = 16;
    localparam int LEAKY_SHIFT = 3;
    localparam int SAT_MAX     = 127;
    localparam int SAT_MIN     = -128;

    typedef enum logic [1:0] {
        MODE_RAW   = 2'b00,
        MODE_RELU  = 2'b01,
        MODE_LEAKY = 2'b10,
        MODE_RQ    = 2'b11
    } mode_e;

    typedef enum logic {
        GRP_FIRST = 1'b0,
        GRP_ACCUM = 1'b1
    } grp_state_e;

    // One beat's control as it walks down the shared pipe.
    typedef struct packed {
        logic                  vld;
        logic                  first;
        logic                  last;
        mode_e                 mode;
        logic [RQ_SCALE_W-1:0] rq_scale;
    } ctl_t;

    function automatic int tap_lane_idx(input int tap, input int lane, input int lanes);
        return tap * lanes + lane;
    endfunction

endpackage

// File: rtl/conv_pe_mac.sv
// One output-channel PE: 3x3xIN_LANES MAC, group accumulate, bias and post-process.
// Latency 4 register stages (products, reduce, accumulate, output).
// Backpressure: every stage holds when en=0; products load only on an accepted beat.
module conv_pe_mac
    import conv_pkg::*;
#(
    parameter int IN_LANES = 8,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int RQ_SHIFT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           take,
    input  logic [9*IN_LANES*DATA_W-1:0]   win,
    input  logic [9*IN_LANES*DATA_W-1:0]   wts,
    input  logic signed [ACC_W-1:0]        bias,
    input  logic                           acc_vld,
    input  logic                           acc_first,
    input  logic                           out_load,
    input  mode_e                          mode,
    input  logic [RQ_SCALE_W-1:0]          rq_scale,
    output logic signed [ACC_W-1:0]        pe_out
);
    localparam int NPROD = 9 * IN_LANES;
    localparam int PW    = 2 * DATA_W;
    localparam int RW    = ACC_W + 17;
    localparam logic signed [RW-1:0] RQ_HALF = RW'(1) << (RQ_SHIFT - 1);
    localparam logic signed [RW-1:0] RQ_MAX  = RW'(SAT_MAX);
    localparam logic signed [RW-1:0] RQ_MIN  = RW'(SAT_MIN);

    logic signed [PW-1:0]    prod_q [NPROD];
    logic signed [PW-1:0]    prod_d [NPROD];
    logic signed [ACC_W-1:0] bias1_q, bias1_d, bias2_q, bias2_d;
    logic signed [ACC_W-1:0] sum_q, sum_d, acc_q, acc_d, out_q, out_d;
    logic signed [ACC_W-1:0] red, post;
    logic signed [RW-1:0]    rq_p, rq_r;

    always_comb begin
        prod_d  = prod_q;
        bias1_d = bias1_q;
        if (take) begin
            bias1_d = bias;
            for (int t = 0; t < 9; t++) begin
                for (int l = 0; l < IN_LANES; l++) begin
                    prod_d[tap_lane_idx(t, l, IN_LANES)] =
                        PW'($signed(win[tap_lane_idx(t, l, IN_LANES)*DATA_W +: DATA_W])) *
                        PW'($signed(wts[tap_lane_idx(t, l, IN_LANES)*DATA_W +: DATA_W]));
                end
            end
        end

        red = '0;
        for (int i = 0; i < NPROD; i++) begin
            red = red + {{(ACC_W-PW){prod_q[i][PW-1]}}, prod_q[i]};
        end
        sum_d   = en ? red : sum_q;
        bias2_d = en ? bias1_q : bias2_q;

        acc_d = acc_q;
        if (acc_vld) begin
            acc_d = acc_first ? bias2_q + sum_q : acc_q + sum_q;
        end

        rq_p = RW'(acc_q) * RW'($signed({1'b0, rq_scale}));
        rq_r = (rq_p + RQ_HALF) >>> RQ_SHIFT;

        post = acc_q;
        case (mode)
            MODE_RAW:   post = acc_q;
            MODE_RELU:  post = acc_q[ACC_W-1] ? '0 : acc_q;
            MODE_LEAKY: post = acc_q[ACC_W-1] ? (acc_q >>> LEAKY_SHIFT) : acc_q;
            MODE_RQ: begin
                if (rq_r > RQ_MAX)      post = ACC_W'(RQ_MAX);
                else if (rq_r < RQ_MIN) post = ACC_W'(RQ_MIN);
                else                    post = ACC_W'(rq_r);
            end
            default:    post = acc_q;
        endcase

        out_d = out_load ? post : out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPROD; i++) prod_q[i] <= '0;
            bias1_q <= '0;
            bias2_q <= '0;
            sum_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            for (int i = 0; i < NPROD; i++) prod_q[i] <= prod_d[i];
            bias1_q <= bias1_d;
            bias2_q <= bias2_d;
            sum_q   <= sum_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign pe_out = out_q;

endmodule

// File: rtl/conv_3x3_array.sv
// N_OUT-PE 3x3 conv array with shared group FSM and control pipe.
// Latency: group-completing beat accepted on edge k gives out_valid after edge k+3.
// Backpressure: whole pipe stalls while out_valid && !out_ready; in_ready mirrors that.
module conv_3x3_array
    import conv_pkg::*;
#(
    parameter int N_OUT    = 8,
    parameter int IN_LANES = 8,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int RQ_SHIFT = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              last_channel,
    input  logic [1:0]                        mode,
    input  logic [RQ_SCALE_W-1:0]             rq_scale,
    input  logic [IN_LANES*DATA_W-1:0]        pixels  [0:2][0:2],
    input  logic [9*IN_LANES*DATA_W-1:0]      weights [0:N_OUT-1],
    input  logic signed [ACC_W-1:0]           biases  [0:N_OUT-1],
    output logic signed [ACC_W-1:0]           outs    [0:N_OUT-1],
    output logic                              out_valid,
    input  logic                              out_ready
);
    localparam int PIX_W = IN_LANES * DATA_W;

    logic       en, take;
    grp_state_e state_q, state_d;
    mode_e      mode_lat_q, mode_lat_d;
    ctl_t       c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic       out_valid_q, out_valid_d;
    logic [9*PIX_W-1:0] win;

    assign en        = !(out_valid_q && !out_ready);
    assign in_ready  = en;
    assign take      = in_valid && en;
    assign out_valid = out_valid_q;

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign win[(r*3+c)*PIX_W +: PIX_W] = pixels[r][c];
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_lat_d  = mode_lat_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        c3_d        = c3_q;
        out_valid_d = out_valid_q;
        if (en) begin
            c1_d = '0;
            if (take) begin
                c1_d.vld      = 1'b1;
                c1_d.first    = (state_q == GRP_FIRST);
                c1_d.last     = last_channel;
                c1_d.mode     = (state_q == GRP_FIRST) ? mode_e'(mode) : mode_lat_q;
                c1_d.rq_scale = rq_scale;
                if (state_q == GRP_FIRST) mode_lat_d = mode_e'(mode);
                state_d = last_channel ? GRP_FIRST : GRP_ACCUM;
            end
            c2_d        = c1_q;
            c3_d        = c2_q;
            out_valid_d = c3_q.vld && c3_q.last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= GRP_FIRST;
            mode_lat_q  <= MODE_RAW;
            c1_q        <= '0;
            c2_q        <= '0;
            c3_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_lat_q  <= mode_lat_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            c3_q        <= c3_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_pe
        conv_pe_mac #(
            .IN_LANES (IN_LANES),
            .DATA_W   (DATA_W),
            .ACC_W    (ACC_W),
            .RQ_SHIFT (RQ_SHIFT)
        ) u_pe (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .take      (take),
            .win       (win),
            .wts       (weights[g]),
            .bias      (biases[g]),
            .acc_vld   (en && c2_q.vld),
            .acc_first (c2_q.first),
            .out_load  (en && c3_q.vld && c3_q.last),
            .mode      (c3_q.mode),
            .rq_scale  (c3_q.rq_scale),
            .pe_out    (outs[g])
        );
    end

endmodule

// File: tb/tb_conv_3x3_array.sv
// Directed self-checking bench for conv_3x3_array.
module tb_conv_3x3_array;
    localparam int N = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, last_channel, out_valid, out_ready;
    logic [1:0]         mode;
    logic [15:0]        rq_scale;
    logic [63:0]        pixels  [0:2][0:2];
    logic [575:0]       weights [0:N-1];
    logic signed [31:0] biases  [0:N-1];
    logic signed [31:0] outs    [0:N-1];

    int errors = 0;
    int checks = 0;

    conv_3x3_array dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .last_channel(last_channel), .mode(mode), .rq_scale(rq_scale),
        .pixels(pixels), .weights(weights), .biases(biases), .outs(outs),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] p, input logic [7:0] w);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) pixels[r][c] = {8{p}};
        for (int n = 0; n < N; n++) weights[n] = {72{w}};
    endtask

    task automatic set_bias(input int b);
        for (int n = 0; n < N; n++) biases[n] = b;
    endtask

    task automatic beat(input logic last, input logic [1:0] m);
        in_valid = 1'b1;
        last_channel = last;
        mode = m;
        tick();
        in_valid = 1'b0;
        last_channel = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        for (int n = 0; n < N; n++) begin
            checks++;
            if (outs[n] !== 32'sd0) begin errors++; $display("FAIL reset_outs[%0d] got %0d want 0", n, outs[n]); end
        end
    endtask

    task automatic test_raw_multibeat();
        set_data(8'sd1, 8'sd1);
        for (int n = 0; n < N; n++) biases[n] = 10 + n;
        beat(1'b0, 2'b00);
        set_bias(999);
        beat(1'b0, 2'b00);
        beat(1'b1, 2'b00);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_latency_%0d out_valid got %b want 0", i, out_valid); end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL raw_out_valid got %b want 1", out_valid); end
        for (int n = 0; n < N; n++) begin
            checks++;
            if (outs[n] !== 226 + n) begin errors++; $display("FAIL raw_outs[%0d] got %0d want %0d", n, outs[n], 226 + n); end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_single_cycle out_valid got %b want 0", out_valid); end
        checks++;
        if (outs[0] !== 32'sd226) begin errors++; $display("FAIL raw_hold got %0d want 226", outs[0]); end
    endtask

    task automatic test_relu_leaky();
        logic [1:0] modes [2];
        int         exps  [2];
        modes[0] = 2'b01; exps[0] = 0;
        modes[1] = 2'b10; exps[1] = -9;
        set_data(8'sd1, 8'hFF);
        set_bias(0);
        for (int k = 0; k < 2; k++) begin
            beat(1'b1, modes[k]);
            tick(); tick(); tick();
            checks++;
            if (out_valid !== 1'b1 || outs[3] !== exps[k])
                begin errors++; $display("FAIL post_mode%0d got v=%b %0d want v=1 %0d", modes[k], out_valid, outs[3], exps[k]); end
            tick();
        end
    endtask

    task automatic test_requant();
        logic [15:0] scales [3];
        logic [7:0]  wts    [3];
        int          bs     [3];
        int          exps   [3];
        scales[0] = 16'h8000; wts[0] = 8'sd1;  bs[0] = 11;  exps[0] = 114;
        scales[1] = 16'hFFFF; wts[1] = 8'sd1;  bs[1] = 11;  exps[1] = 127;
        scales[2] = 16'hFFFF; wts[2] = 8'hFF;  bs[2] = -11; exps[2] = -128;
        for (int k = 0; k < 3; k++) begin
            set_data(8'sd1, wts[k]);
            set_bias(bs[k]);
            rq_scale = 16'h0003;
            beat(1'b0, 2'b11);
            beat(1'b0, 2'b11);
            rq_scale = scales[k];
            beat(1'b1, 2'b11);
            tick(); tick(); tick();
            checks++;
            if (out_valid !== 1'b1 || outs[5] !== exps[k])
                begin errors++; $display("FAIL requant_%0d got v=%b %0d want v=1 %0d", k, out_valid, outs[5], exps[k]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        set_data(8'sd1, 8'sd1);
        set_bias(10);
        out_ready = 1'b0;
        beat(1'b0, 2'b00);
        beat(1'b0, 2'b00);
        beat(1'b1, 2'b00);
        tick(); tick(); tick();
        set_bias(0);
        in_valid = 1'b1;
        last_channel = 1'b1;
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || outs[1] !== 32'sd226)
                begin errors++; $display("FAIL bp_hold_%0d got rdy=%b v=%b %0d want rdy=0 v=1 226", i, in_ready, out_valid, outs[1]); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        last_channel = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || outs[1] !== 32'sd226)
            begin errors++; $display("FAIL bp_consume got v=%b %0d want v=0 226", out_valid, outs[1]); end
        tick(); tick(); tick();
        checks++;
        if (out_valid !== 1'b1 || outs[1] !== 32'sd72)
            begin errors++; $display("FAIL bp_group_b got v=%b %0d want v=1 72", out_valid, outs[1]); end
        tick();
    endtask

    task automatic test_reset_mid_group();
        set_data(8'sd1, 8'sd1);
        set_bias(100);
        beat(1'b0, 2'b01);
        beat(1'b0, 2'b01);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || outs[2] !== 32'sd0)
            begin errors++; $display("FAIL midrst_clear got v=%b %0d want v=0 0", out_valid, outs[2]); end
        set_bias(5);
        beat(1'b1, 2'b00);
        tick(); tick(); tick();
        checks++;
        if (out_valid !== 1'b1 || outs[2] !== 32'sd77)
            begin errors++; $display("FAIL midrst_group got v=%b %0d want v=1 77", out_valid, outs[2]); end
        tick();
    endtask

    task automatic test_mode_latch();
        set_data(8'sd1, 8'hFF);
        set_bias(144);
        beat(1'b0, 2'b10);
        set_bias(0);
        beat(1'b0, 2'b00);
        beat(1'b1, 2'b00);
        tick(); tick(); tick();
        checks++;
        if (out_valid !== 1'b1 || outs[7] !== -32'sd9)
            begin errors++; $display("FAIL mode_latch got v=%b %0d want v=1 -9", out_valid, outs[7]); end
        tick();
    endtask

    task automatic test_back_to_back();
        set_data(8'sd1, 8'sd1);
        set_bias(1);
        beat(1'b1, 2'b00);
        set_bias(2);
        beat(1'b1, 2'b00);
        tick(); tick();
        checks++;
        if (out_valid !== 1'b1 || outs[4] !== 32'sd73)
            begin errors++; $display("FAIL b2b_first got v=%b %0d want v=1 73", out_valid, outs[4]); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || outs[4] !== 32'sd74)
            begin errors++; $display("FAIL b2b_second got v=%b %0d want v=1 74", out_valid, outs[4]); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain out_valid got %b want 0", out_valid); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        last_channel = 1'b0;
        mode = 2'b00;
        rq_scale = 16'h0;
        out_ready = 1'b1;
        set_data(8'h0, 8'h0);
        set_bias(0);
        #12;
        test_reset();
        rst = 1'b0;
        tick();
        test_raw_multibeat();
        test_relu_leaky();
        test_requant();
        test_backpressure();
        test_reset_mid_group();
        test_mode_latch();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
